// File: rtl/rx_replay_pkg.sv
// rx_replay_pkg
//   Shared definitions for the rx frame replay source.
//   - rx_replay_state_t : frame sequencer states
//   - GAP_CNT_W         : width of the idle-gap counter (GAP range 0..255)
package rx_replay_pkg;

  localparam int GAP_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SOC     = 3'd1,
    ST_GAP     = 3'd2,
    ST_ERR     = 3'd3,
    ST_ERR_GAP = 3'd4,
    ST_DATA    = 3'd5,
    ST_EOC     = 3'd6
  } rx_replay_state_t;

endpackage

// File: rtl/rx_replay_buffer.sv
// rx_replay_buffer
//   Frame item store for the replay source: DEPTH x DATA_WIDTH storage with
//   write/read pointers, an item count and a full flag. Writes while full are
//   dropped. i_clr empties the buffer synchronously (same effect as i_rst).
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_clr            synchronous clear of pointers and count
//   i_wr_en/i_wr_data push one item (ignored when full)
//   i_rd_adv         advance the read pointer by one item
//   o_rd_data        item at the read pointer (combinational read)
//   o_count, o_full  number of stored items, count == DEPTH
import rx_replay_pkg::*;

module rx_replay_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_clr,
  input  logic                    i_wr_en,
  input  logic [DATA_WIDTH-1:0]   i_wr_data,
  input  logic                    i_rd_adv,
  output logic [DATA_WIDTH-1:0]   o_rd_data,
  output logic [$clog2(DEPTH):0]  o_count,
  output logic                    o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_V = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [AW:0]           r_count;
  logic                  w_push;

  assign o_full    = (r_count == DEPTH_V);
  assign w_push    = i_wr_en && !o_full;
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
        r_count  <= r_count + CNT_ONE;
      end
      if (i_rd_adv) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
    end
  end

  // Storage carries no reset; emptiness is tracked by the pointers alone.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_rst && !i_clr) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

endmodule

// File: rtl/rx_frame_replay_source.sv
// rx_frame_replay_source
//   Replays a buffered frame onto an rx_interface-style output:
//   SOC, then each item preceded by GAP idle cycles, then GAP idle cycles
//   and EOC. Optional partial last byte (BY_BYTE=1) rides on the EOC cycle.
//   Optional error injection is compiled in with RX_REPLAY_ERROR_INJECT_EN;
//   without it, error is tied 0 and error_en/error_index are ignored.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wr_en, wr_data, wr_full  buffer load (accepted only in IDLE, not full)
//   start                    begin a frame (sampled only in IDLE)
//   bits_in_last             valid bits of last item, 0 = full (latched at start)
//   error_en, error_index    error injection control (latched at start)
//   busy, done               frame in progress / one-cycle pulse with eoc
//   soc, eoc, data_valid, error, data, data_bits   interface outputs
//   dbg_state                current sequencer state
// Interface strobes: every strobe is a registered single-cycle pulse; data
// and data_bits are meaningful only while data_valid is high (0 otherwise).
// There is no back-pressure: the consumer must accept every data_valid cycle.
import rx_replay_pkg::*;

module rx_frame_replay_source #(
  parameter int DATA_WIDTH = 8,
  parameter int BY_BYTE    = 1,
  parameter int DEPTH      = 32,
  parameter int GAP        = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    wr_full,
  input  logic                    start,
  input  logic [2:0]              bits_in_last,
  input  logic                    error_en,
  input  logic [$clog2(DEPTH):0]  error_index,
  output logic                    busy,
  output logic                    done,
  output logic                    soc,
  output logic                    eoc,
  output logic                    data_valid,
  output logic                    error,
  output logic [DATA_WIDTH-1:0]   data,
  output logic [2:0]              data_bits,
  output logic [2:0]              dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [GAP_CNT_W-1:0] GAP_V   = GAP_CNT_W'(GAP);
  localparam logic [GAP_CNT_W-1:0] GAP_ONE = GAP_CNT_W'(1);
  localparam logic [AW:0]          IDX_ONE = (AW+1)'(1);
  localparam bit                   GAP_ZERO = (GAP == 0);

  rx_replay_state_t r_state;
  rx_replay_state_t w_next;
  rx_replay_state_t w_after_gap;

  logic [GAP_CNT_W-1:0]  r_gap_cnt;
  logic [AW:0]           r_idx;
  logic [AW:0]           r_n_full;
  logic                  r_has_partial;
  logic [2:0]            r_bits_last;

  logic                  r_busy;
  logic                  r_soc;
  logic                  r_eoc;
  logic                  r_done;
  logic                  r_dv;
  logic [DATA_WIDTH-1:0] r_data;
  logic [2:0]            r_data_bits;

  logic                  w_wr;
  logic                  w_rd_adv;
  logic                  w_clr;
  logic                  w_full;
  logic [AW:0]           w_count;
  logic [AW:0]           w_count_post;
  logic [AW:0]           w_n_full;
  logic                  w_partial_req;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_err_pending;
  logic                  w_eoc_partial;

  // Loads are only accepted between frames.
  assign w_wr     = wr_en && (r_state == ST_IDLE) && !w_full;
  assign w_rd_adv = (w_next == ST_DATA);
  assign w_clr    = (r_state == ST_EOC);

  rx_replay_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_buffer (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clr     (w_clr),
    .i_wr_en   (w_wr),
    .i_wr_data (wr_data),
    .i_rd_adv  (w_rd_adv),
    .o_rd_data (w_rd_data),
    .o_count   (w_count),
    .o_full    (w_full)
  );

  // Item split is computed on the post-write count so that a write in the
  // same cycle as start is part of the frame. The last buffered item is the
  // partial one, so it stays behind the read pointer until EOC.
  always_comb begin
    w_count_post  = w_count + ((w_wr) ? IDX_ONE : '0);
    w_partial_req = (BY_BYTE != 0) && (bits_in_last != 3'd0) && (w_count_post != '0);
    w_n_full      = w_partial_req ? (w_count_post - IDX_ONE) : w_count_post;
  end

`ifdef RX_REPLAY_ERROR_INJECT_EN
  logic        r_err_en;
  logic        r_err_sent;
  logic [AW:0] r_err_idx;
  logic        r_error;

  assign w_err_pending = r_err_en && !r_err_sent;
  assign error         = r_error;
`else
  logic w_unused_err;

  assign w_err_pending = 1'b0;
  assign w_unused_err  = ^{error_en, error_index};
  assign error         = 1'b0;
`endif

  // Exit taken at the end of any idle gap (or immediately when GAP == 0).
  always_comb begin
    w_after_gap = (r_idx < r_n_full) ? ST_DATA : ST_EOC;
`ifdef RX_REPLAY_ERROR_INJECT_EN
    if (w_err_pending && (r_err_idx == r_idx)) begin
      w_after_gap = ST_ERR;
    end
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (start) w_next = ST_SOC;
      ST_SOC,
      ST_DATA:    w_next = GAP_ZERO ? w_after_gap : ST_GAP;
      ST_GAP:     if (r_gap_cnt == GAP_ONE) w_next = w_after_gap;
`ifdef RX_REPLAY_ERROR_INJECT_EN
      ST_ERR:     w_next = GAP_ZERO ? w_after_gap : ST_ERR_GAP;
      ST_ERR_GAP: if (r_gap_cnt == GAP_ONE) w_next = w_after_gap;
`endif
      ST_EOC:     w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Partial item is dropped from EOC when the pending error takes that slot.
  assign w_eoc_partial = r_has_partial && !w_err_pending;

  // All side effects happen on the edge entering a state, so the registered
  // outputs line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_gap_cnt     <= '0;
      r_idx         <= '0;
      r_n_full      <= '0;
      r_has_partial <= 1'b0;
      r_bits_last   <= 3'd0;
      r_busy        <= 1'b0;
      r_soc         <= 1'b0;
      r_eoc         <= 1'b0;
      r_done        <= 1'b0;
      r_dv          <= 1'b0;
      r_data        <= '0;
      r_data_bits   <= 3'd0;
    end else begin
      r_state <= w_next;

      // Counter holds the idle cycles remaining, including the current one.
      if ((w_next == ST_GAP) || (w_next == ST_ERR_GAP)) begin
        r_gap_cnt <= (r_state == w_next) ? (r_gap_cnt - GAP_ONE) : GAP_V;
      end

      if ((r_state == ST_IDLE) && start) begin
        r_idx         <= '0;
        r_n_full      <= w_n_full;
        r_has_partial <= w_partial_req;
        r_bits_last   <= bits_in_last;
      end else if (w_next == ST_DATA) begin
        r_idx <= r_idx + IDX_ONE;
      end

      r_busy <= (w_next != ST_IDLE);
      r_soc  <= (w_next == ST_SOC);
      r_eoc  <= (w_next == ST_EOC);
      r_done <= (w_next == ST_EOC);

      if ((w_next == ST_DATA) || ((w_next == ST_EOC) && w_eoc_partial)) begin
        r_dv   <= 1'b1;
        r_data <= w_rd_data;
      end else begin
        r_dv   <= 1'b0;
        r_data <= '0;
      end
      r_data_bits <= ((w_next == ST_EOC) && w_eoc_partial) ? r_bits_last : 3'd0;
    end
  end

`ifdef RX_REPLAY_ERROR_INJECT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_en   <= 1'b0;
      r_err_sent <= 1'b0;
      r_err_idx  <= '0;
      r_error    <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && start) begin
        r_err_en   <= error_en;
        r_err_idx  <= error_index;
        r_err_sent <= 1'b0;
      end else if (w_next == ST_ERR) begin
        r_err_sent <= 1'b1;
      end
      r_error <= (w_next == ST_ERR) || ((w_next == ST_EOC) && w_err_pending);
    end
  end
`endif

  assign wr_full    = w_full;
  assign busy       = r_busy;
  assign done       = r_done;
  assign soc        = r_soc;
  assign eoc        = r_eoc;
  assign data_valid = r_dv;
  assign data       = r_data;
  assign data_bits  = r_data_bits;
  assign dbg_state  = r_state;

endmodule
